// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic pipeline stage register carrying an opaque WIDTH-bit payload with a
// valid/ready handshake, synchronous flush (bubble insertion), freeze (global
// stall) and a saturating count of cycles in which the head entry was held.
//
// Build option (macro PIPE_STAGE_SKID_EN):
//   defined   : 2-entry skid buffer, in_ready derived only from state and freeze
//               (no combinational out_ready -> in_ready path).
//   undefined : single-entry register, in_ready depends on out_ready so an
//               entry can be accepted in the same cycle the old one drains.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_b      in   asynchronous active-low reset
//   in_valid   in   upstream presents a payload
//   in_ready   out  stage accepts a payload this cycle
//   in_data    in   upstream payload [WIDTH]
//   out_valid  out  stage presents its head payload
//   out_ready  in   downstream accepts this cycle
//   out_data   out  head payload [WIDTH] (holds last value when not valid)
//   flush      in   discard all held entries at the next edge (highest priority)
//   freeze     in   hold all state; masks in_ready and out_valid
//   stall_cnt  out  saturating held-cycle counter [CNT_W], cleared by reset only
// ----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    input  logic             freeze,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             up_xfer;
    logic             dn_xfer;
    logic             held;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;

`ifdef PIPE_STAGE_SKID_EN
    // ------------------------------------------------------------------
    // Two-entry skid buffer: head feeds the output, skid catches the one
    // payload that may arrive while downstream is not accepting.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;

    // in_ready comes from the state register, never from out_ready.
    assign in_ready  = !freeze && (state_q != ST_TWO);
    assign out_valid = !freeze && (state_q != ST_EMPTY);
    assign held      = (state_q != ST_EMPTY);
    assign up_xfer   = in_valid && in_ready;
    assign dn_xfer   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_EMPTY;
            head_q  <= RST_VAL;
            skid_q  <= RST_VAL;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            // Only the occupancy clears; payload registers keep old contents.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (up_xfer) begin
                        head_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (up_xfer && dn_xfer) begin
                        head_d = in_data;
                    end else if (up_xfer) begin
                        skid_d  = in_data;
                        state_d = ST_TWO;
                    end else if (dn_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a drain can occur.
                    if (dn_xfer) begin
                        head_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end
`else
    // ------------------------------------------------------------------
    // Single-entry register; accepting while draining keeps full rate.
    // ------------------------------------------------------------------
    logic full_q;
    logic full_d;

    assign in_ready  = !freeze && (!full_q || out_ready);
    assign out_valid = !freeze && full_q;
    assign held      = full_q;
    assign up_xfer   = in_valid && in_ready;
    assign dn_xfer   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            full_q <= 1'b0;
            head_q <= RST_VAL;
        end else begin
            full_q <= full_d;
            head_q <= head_d;
        end
    end

    always_comb begin
        full_d = full_q;
        head_d = head_q;
        if (flush) begin
            full_d = 1'b0;
        end else if (up_xfer) begin
            head_d = in_data;
            full_d = 1'b1;
        end else if (dn_xfer) begin
            full_d = 1'b0;
        end
    end
`endif

    assign out_data = head_q;

    // ------------------------------------------------------------------
    // Held-cycle counter: counts backpressure or freeze while an entry is
    // present, ignores flush cycles, saturates at all-ones.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (held && (!out_ready || freeze) && !flush &&
            (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg (WIDTH=32, CNT_W=4). A queue-based
// reference model (capacity 2 with PIPE_STAGE_SKID_EN, else 1) predicts
// in_ready, out_valid, out_data and stall_cnt every cycle. Directed scenarios
// are followed by randomized traffic with periodic mid-stream resets.
// ----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int W  = 32;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          flush;
    logic          freeze;
    logic [CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [W-1:0] mq[$];
    logic [W-1:0] m_last;
    int           m_cnt;

    pipe_stage_reg #(
        .WIDTH  (W),
        .RST_VAL('0),
        .CNT_W  (CW)
    ) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .flush    (flush),
        .freeze   (freeze),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic exp_in_ready(input logic ordy, input logic fz);
`ifdef PIPE_STAGE_SKID_EN
        return !fz && (mq.size() < 2);
`else
        return !fz && ((mq.size() == 0) || ordy);
`endif
    endfunction

    // One clock cycle: drive at negedge, check outputs, advance model at posedge.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy,
                        input logic fl, input logic fz);
        logic e_ir;
        logic e_ov;
        logic up;
        logic dn;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        freeze    = fz;
        #1;
        e_ir = exp_in_ready(ordy, fz);
        e_ov = !fz && (mq.size() > 0);
        check_eq("in_ready",  32'(in_ready),  32'(e_ir));
        check_eq("out_valid", 32'(out_valid), 32'(e_ov));
        check_eq("out_data",  out_data,       m_last);
        check_eq("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        up = iv && e_ir;
        dn = e_ov && ordy;
        if (dn) $display("xfer out data=0x%08h", mq[0]);
        @(posedge clk);
        if ((mq.size() > 0) && (!ordy || fz) && !fl && (m_cnt < CNT_MAX)) m_cnt++;
        if (fl) begin
            mq.delete();
        end else begin
            if (dn) void'(mq.pop_front());
            if (up) mq.push_back(d);
        end
        if (mq.size() > 0) m_last = mq[0];
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        freeze = 1'b0;
        flush  = 1'b0;
        #2;
        rst_b = 1'b0;
        #1;
        mq.delete();
        m_last = '0;
        m_cnt  = 0;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data",  out_data,       32'd0);
        check_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        $display("reset applied");
    endtask

    initial begin
        rst_b     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        freeze    = 1'b0;
        m_last    = '0;
        m_cnt     = 0;
        repeat (2) @(negedge clk);
        check_eq("init_out_valid", 32'(out_valid), 32'd0);
        check_eq("init_out_data",  out_data,       32'd0);
        check_eq("init_stall_cnt", 32'(stall_cnt), 32'd0);
        rst_b = 1'b1;
        #1;
        check_eq("init_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Streaming
        step(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0);

        // Backpressure: B is retried until accepted
        step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Freeze with an entry held
        step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 32'h5A, 1'b1, 1'b0, 1'b1);
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush beats freeze and an incoming payload
        step(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h77, 1'b0, 1'b1, 1'b1);
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Saturation
        step(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of traffic
        step(1'b1, 32'hC0FFEE, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hBEEF,   1'b0, 1'b0, 1'b0);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ((i % 100) == 99) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     $urandom,
                     $urandom_range(0, 2) != 0,
                     $urandom_range(0, 15) == 0,
                     $urandom_range(0, 5) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed-field inter-stage registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB) with one generic block. It carries an opaque WIDTH-bit payload and adds a valid/ready handshake, flush (bubble insertion), freeze (stall), and a saturating stall-cycle counter. Stages instantiate it with their control and data fields concatenated into `in_data`.

## Interface
Parameters:
- `WIDTH`, 32: payload width in bits, must be at least 1.
- `RST_VAL`, 0: value of `out_data` and all payload storage after reset.
- `CNT_W`, 16: width of `stall_cnt`.

Ports (one clock `clk`; reset `rst_b` is asynchronous and active-low):
- `clk`, in, 1: rising-edge clock.
- `rst_b`, in, 1: asynchronous active-low reset.
- `in_valid`, in, 1: upstream presents a payload.
- `in_ready`, out, 1: the stage accepts a payload this cycle.
- `in_data`, in, WIDTH: upstream payload.
- `out_valid`, out, 1: the stage presents a payload downstream.
- `out_ready`, in, 1: downstream accepts this cycle.
- `out_data`, out, WIDTH: head payload.
- `flush`, in, 1: synchronous discard of every held entry.
- `freeze`, in, 1: global hazard/cache stall; holds all state.
- `stall_cnt`, out, CNT_W: cycles in which the head was held back (backpressure or freeze).

## Operation
- An upstream transfer happens when `in_valid & in_ready`. A downstream transfer happens when `out_valid & out_ready`.
- Entries are FIFO-ordered. Payloads are never reordered, duplicated or modified.
- **freeze = 1:**
  - `in_ready` and `out_valid` are forced to 0.
  - Entries, data and state do not change.
  - `stall_cnt` increments if at least one entry is held.
- **flush = 1:** takes priority over freeze and over any transfer.
  - All entries are invalidated at the next edge.
  - The `in_data` presented that cycle is dropped.
  - Payload registers keep their old contents; only the valid bits clear.
  - `stall_cnt` is unaffected by flush.
- **stall_cnt:**
  - Increments on every cycle with an entry held while `(!out_ready | freeze)` and `!flush`.
  - Saturates at all-ones.
  - Cleared only by reset.
- **Reset (asynchronous):** `out_valid`=0, `out_data`=RST_VAL, all valid bits 0, `stall_cnt`=0. Once `freeze`=0, `in_ready` reads 1 immediately.
- **With skid (see Configuration):** two-state-bit FSM with states EMPTY, ONE, TWO.
  - EMPTY → ONE on an upstream transfer.
  - ONE → TWO on an upstream transfer without a downstream transfer.
  - ONE → EMPTY on a downstream transfer without an upstream transfer.
  - ONE stays ONE when both transfer.
  - TWO → ONE on a downstream transfer. The skid entry moves into the head; `in_ready`=0 in TWO.
  - Any state → EMPTY on flush.
- **Without skid:** one entry.
  - `in_ready = !freeze & (!full | out_ready)`.
  - Accept and drain in the same cycle, giving full throughput.

## Timing
- Latency is 1 cycle: a payload accepted at edge N is on `out_data` with `out_valid`=1 after edge N.
- Throughput is 1 payload per cycle when `out_ready`=1 and `freeze`=0.
- With skid, `in_ready` is a register output: `in_ready = !freeze & (state != TWO)`. There is no combinational path from `out_ready` to `in_ready`.
- Without skid, `in_ready` depends combinationally on `out_ready`.
- `out_data` and `out_valid` are registered. The only combinational input is freeze masking.
- `out_data` holds its last value when `out_valid`=0; downstream must not sample it.
- Reset asserted mid-transfer aborts immediately, and the entry is lost.
- Flush and an upstream transfer in the same cycle: the flush wins and the stage is empty after the edge.
- Deasserting freeze resumes from exactly the pre-freeze state. No entry is lost or replayed.

## Configuration
- Macro `PIPE_STAGE_SKID_EN`:
  - **Defined:** a 2-entry skid buffer and a registered `in_ready`, which breaks the ready chain for timing closure.
  - **Undefined:** a single-entry register with a combinational `in_ready`. Storage area is halved.
- Functional ordering, latency, flush, freeze and `stall_cnt` behaviour are identical in both builds. Only `in_ready` timing and capacity (2 vs 1) differ.

## Test plan
Run each scenario with the macro both defined and undefined; WIDTH=32, CNT_W=4.
1. **Reset.** Assert `rst_b`=0 mid-stream → `out_valid`=0, `out_data`=0, `stall_cnt`=0 asynchronously. Release with `freeze`=0 → `in_ready`=1.
2. **Streaming.** Send 0x11, 0x22, 0x33 on consecutive cycles with `out_ready`=1 → outputs appear one cycle later, in order, with no gap.
3. **Backpressure.** Hold `out_ready`=0 while sending 0xA, 0xB.
   - Skid build: both accepted, then `in_ready`=0.
   - Non-skid build: only 0xA accepted.
   - Release `out_ready` → 0xA then 0xB; `stall_cnt` equals the held cycles.
4. **Freeze.** Assert freeze for 3 cycles with 0x55 held → `out_valid`=0, `in_ready`=0, `stall_cnt`+=3. Release → 0x55 delivered once.
5. **Flush priority.** Assert flush with `freeze`=1 and `in_valid`=1 (0x77) while holding 0x66 → next cycle `out_valid`=0, and neither 0x66 nor 0x77 ever appears.
6. **Saturation.** Hold an entry with `out_ready`=0 for 20 cycles → `stall_cnt` stops at 0xF.
